// File: rtl/channel_mixer_pkg.sv
// Shared constants, types and the sample clamp used by the channel mixer.
package channel_mixer_pkg;

  localparam int unsigned OP_OUT_WIDTH          = 13;
  localparam int unsigned SAMPLE_WIDTH          = 16;
  localparam int unsigned NUM_BANKS             = 2;
  localparam int unsigned NUM_CHANNELS_PER_BANK = 9;
  localparam int unsigned MIX_ACC_WIDTH         = OP_OUT_WIDTH + 7;
  localparam int unsigned CLIP_CNT_WIDTH        = 16;

  localparam logic signed [MIX_ACC_WIDTH-1:0] SAMPLE_MAX =
      MIX_ACC_WIDTH'((1 << (SAMPLE_WIDTH - 1)) - 1);
  localparam logic signed [MIX_ACC_WIDTH-1:0] SAMPLE_MIN =
      MIX_ACC_WIDTH'(-(1 << (SAMPLE_WIDTH - 1)));

  typedef enum logic {
    MODULATOR = 1'b0,
    CARRIER   = 1'b1
  } op_slot_t;

  typedef enum logic {
    StAccum,
    StFlush
  } mix_state_t;

  function automatic logic signed [SAMPLE_WIDTH-1:0] saturate_sample(
      input logic signed [MIX_ACC_WIDTH-1:0] acc);
    if (acc > SAMPLE_MAX) begin
      return {1'b0, {(SAMPLE_WIDTH - 1){1'b1}}};
    end else if (acc < SAMPLE_MIN) begin
      return {1'b1, {(SAMPLE_WIDTH - 1){1'b0}}};
    end else begin
      return acc[SAMPLE_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/mixer_saturate.sv
// Combinational clamp of one accumulator side to the sample range, with a clip flag.
module mixer_saturate
  import channel_mixer_pkg::*;
(
  input  logic signed [MIX_ACC_WIDTH-1:0] acc,
  output logic signed [SAMPLE_WIDTH-1:0]  sample,
  output logic                            clip
);

  assign sample = saturate_sample(acc);
  assign clip   = (acc > SAMPLE_MAX) || (acc < SAMPLE_MIN);

endmodule

// File: rtl/channel_mixer.sv
// Forms 2-op channel results, pans and accumulates them per frame, emits saturated stereo.
// Optional clip counter enabled by defining CHANNEL_MIXER_CLIP_CNT_EN.
module channel_mixer
  import channel_mixer_pkg::*;
(
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  sample_clk_en,
  input  logic                                                  op_valid,
  input  logic                                                  op_bank,
  input  logic [3:0]                                            op_chan,
  input  logic                                                  op_slot,
  input  logic signed [OP_OUT_WIDTH-1:0]                        op_out,
  input  logic [NUM_BANKS-1:0][NUM_CHANNELS_PER_BANK-1:0]       cnt,
  input  logic [NUM_BANKS-1:0][NUM_CHANNELS_PER_BANK-1:0]       cha,
  input  logic [NUM_BANKS-1:0][NUM_CHANNELS_PER_BANK-1:0]       chb,
  input  logic                                                  is_new,
  input  logic                                                  ryt,
  output logic signed [SAMPLE_WIDTH-1:0]                        sample_l,
  output logic signed [SAMPLE_WIDTH-1:0]                        sample_r,
  output logic                                                  sample_valid
`ifdef CHANNEL_MIXER_CLIP_CNT_EN
  ,
  output logic [CLIP_CNT_WIDTH-1:0]                             clip_count
`endif
);

  localparam int unsigned ACC_WIDTH = MIX_ACC_WIDTH;
  localparam int unsigned SUM_WIDTH = OP_OUT_WIDTH + 1;

  logic [NUM_BANKS-1:0][NUM_CHANNELS_PER_BANK-1:0][OP_OUT_WIDTH-1:0] mod_q;
  logic signed [ACC_WIDTH-1:0] acc_l_q, acc_r_q;
  mix_state_t                  state_q;

  op_slot_t                    slot;
  logic                        chan_ok, mod_we, car_en, rhythm_ch, to_l, to_r;
  logic [3:0]                  chan_idx;
  logic signed [OP_OUT_WIDTH-1:0] mod_val;
  logic signed [SUM_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] ext_op, ext_sum, ch_base, ch, add_l, add_r;
  logic signed [SAMPLE_WIDTH-1:0] sat_l, sat_r;
  logic                        clip_l, clip_r;

  always_comb begin
    slot      = op_slot_t'(op_slot);
    chan_ok   = op_chan < 4'(NUM_CHANNELS_PER_BANK);
    chan_idx  = chan_ok ? op_chan : 4'd0;
    mod_we    = op_valid && chan_ok && (slot == MODULATOR);
    car_en    = op_valid && chan_ok && (slot == CARRIER);
    mod_val   = signed'(mod_q[op_bank][chan_idx]);
    sum       = {mod_val[OP_OUT_WIDTH-1], mod_val} + {op_out[OP_OUT_WIDTH-1], op_out};
    ext_op    = {{(ACC_WIDTH - OP_OUT_WIDTH){op_out[OP_OUT_WIDTH-1]}}, op_out};
    ext_sum   = {{(ACC_WIDTH - SUM_WIDTH){sum[SUM_WIDTH-1]}}, sum};
    rhythm_ch = ryt && (op_bank == 1'b0) && (chan_idx >= 4'd6);
    // Rhythm channels ignore cnt: ch6 is carrier-only, ch7/ch8 always sum both ops
    if (rhythm_ch) begin
      ch_base = (chan_idx == 4'd6) ? ext_op : ext_sum;
    end else begin
      ch_base = cnt[op_bank][chan_idx] ? ext_sum : ext_op;
    end
    ch    = rhythm_ch ? (ch_base <<< 1) : ch_base;
    to_l  = car_en && (cha[op_bank][chan_idx] || !is_new);
    to_r  = car_en && (chb[op_bank][chan_idx] || !is_new);
    add_l = to_l ? ch : '0;
    add_r = to_r ? ch : '0;
  end

  mixer_saturate u_sat_l (
    .acc    (acc_l_q),
    .sample (sat_l),
    .clip   (clip_l)
  );

  mixer_saturate u_sat_r (
    .acc    (acc_r_q),
    .sample (sat_r),
    .clip   (clip_r)
  );

  // On the strobe edge the old frame is sampled while the accumulators and modulator
  // registers restart from whatever this cycle's operator contributes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StAccum;
      acc_l_q      <= '0;
      acc_r_q      <= '0;
      mod_q        <= '0;
      sample_l     <= '0;
      sample_r     <= '0;
      sample_valid <= 1'b0;
    end else begin
      case (state_q)
        StAccum: state_q <= sample_clk_en ? StFlush : StAccum;
        StFlush: state_q <= sample_clk_en ? StFlush : StAccum;
        default: state_q <= StAccum;
      endcase
      sample_valid <= sample_clk_en;
      if (sample_clk_en) begin
        sample_l <= sat_l;
        sample_r <= sat_r;
        acc_l_q  <= add_l;
        acc_r_q  <= add_r;
        mod_q    <= '0;
      end else begin
        acc_l_q <= acc_l_q + add_l;
        acc_r_q <= acc_r_q + add_r;
      end
      if (mod_we) begin
        mod_q[op_bank][chan_idx] <= op_out;
      end
    end
  end

`ifdef CHANNEL_MIXER_CLIP_CNT_EN
  localparam int unsigned CLIP_SUM_WIDTH = CLIP_CNT_WIDTH + 1;

  logic [1:0]                clip_inc;
  logic [CLIP_SUM_WIDTH-1:0] clip_sum;

  assign clip_inc = {1'b0, clip_l} + {1'b0, clip_r};
  assign clip_sum = {1'b0, clip_count} + CLIP_SUM_WIDTH'(clip_inc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clip_count <= '0;
    end else if (sample_clk_en) begin
      clip_count <= clip_sum[CLIP_CNT_WIDTH] ? '1 : clip_sum[CLIP_CNT_WIDTH-1:0];
    end
  end
`else
  logic unused_clip;
  assign unused_clip = clip_l ^ clip_r;
`endif

endmodule

// File: tb/tb_channel_mixer.sv
// Directed self-checking bench for channel_mixer with hand-computed expected samples.
module tb_channel_mixer;
  import channel_mixer_pkg::*;

  logic                                            clk = 1'b0;
  logic                                            reset;
  logic                                            sample_clk_en;
  logic                                            op_valid;
  logic                                            op_bank;
  logic [3:0]                                      op_chan;
  logic                                            op_slot;
  logic signed [OP_OUT_WIDTH-1:0]                  op_out;
  logic [NUM_BANKS-1:0][NUM_CHANNELS_PER_BANK-1:0] cnt, cha, chb;
  logic                                            is_new, ryt;
  logic signed [SAMPLE_WIDTH-1:0]                  sample_l, sample_r;
  logic                                            sample_valid;
`ifdef CHANNEL_MIXER_CLIP_CNT_EN
  logic [CLIP_CNT_WIDTH-1:0]                       clip_count;
`endif

  int checks = 0;
  int errors = 0;

  channel_mixer dut (
    .clk           (clk),
    .reset         (reset),
    .sample_clk_en (sample_clk_en),
    .op_valid      (op_valid),
    .op_bank       (op_bank),
    .op_chan       (op_chan),
    .op_slot       (op_slot),
    .op_out        (op_out),
    .cnt           (cnt),
    .cha           (cha),
    .chb           (chb),
    .is_new        (is_new),
    .ryt           (ryt),
    .sample_l      (sample_l),
    .sample_r      (sample_r),
    .sample_valid  (sample_valid)
`ifdef CHANNEL_MIXER_CLIP_CNT_EN
    ,
    .clip_count    (clip_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int bank, input int chan, input int slot, input int val);
    op_valid = 1'b1;
    op_bank  = bank[0];
    op_chan  = chan[3:0];
    op_slot  = slot[0];
    op_out   = OP_OUT_WIDTH'(val);
    cycle();
    op_valid = 1'b0;
  endtask

  task automatic frame(input string tag, input int exp_l, input int exp_r);
    check({tag, "_prevalid"}, int'(sample_valid), 0);
    sample_clk_en = 1'b1;
    cycle();
    sample_clk_en = 1'b0;
    check({tag, "_valid"}, int'(sample_valid), 1);
    check({tag, "_l"}, int'(sample_l), exp_l);
    check({tag, "_r"}, int'(sample_r), exp_r);
    cycle();
    check({tag, "_valid_off"}, int'(sample_valid), 0);
    check({tag, "_hold_l"}, int'(sample_l), exp_l);
  endtask

  initial begin
    reset = 1'b1;
    sample_clk_en = 1'b0;
    op_valid = 1'b0;
    op_bank = 1'b0;
    op_chan = 4'd0;
    op_slot = 1'b0;
    op_out = '0;
    cnt = '0;
    cha = '1;
    chb = '1;
    is_new = 1'b1;
    ryt = 1'b0;
    repeat (3) cycle();
    check("rst_l", int'(sample_l), 0);
    check("rst_r", int'(sample_r), 0);
    check("rst_valid", int'(sample_valid), 0);
`ifdef CHANNEL_MIXER_CLIP_CNT_EN
    check("rst_clip", int'(clip_count), 0);
`endif
    reset = 1'b0;
    cycle();

    // FM single channel
    op(0, 0, 0, 100);
    op(0, 0, 1, -200);
    frame("fm", -200, -200);

    // AM with left-only pan, then OPL2 mode forcing both sides
    cnt[0][0] = 1'b1;
    chb[0][0] = 1'b0;
    op(0, 0, 0, 300);
    op(0, 0, 1, 400);
    frame("am_pan", 700, 0);
    is_new = 1'b0;
    op(0, 0, 0, 300);
    op(0, 0, 1, 400);
    frame("am_opl2", 700, 700);
    is_new = 1'b1;
    chb = '1;

    // Saturation in both directions on all 18 AM channels
    cnt = '1;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 9; c++) begin
        op(b, c, 0, 4095);
        op(b, c, 1, 4095);
      end
    end
    frame("sat_pos", 32767, 32767);
`ifdef CHANNEL_MIXER_CLIP_CNT_EN
    check("clip_pos", int'(clip_count), 2);
`endif
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 9; c++) begin
        op(b, c, 0, -4096);
        op(b, c, 1, -4096);
      end
    end
    frame("sat_neg", -32768, -32768);
`ifdef CHANNEL_MIXER_CLIP_CNT_EN
    check("clip_neg", int'(clip_count), 4);
`endif

    // Rhythm: ch6 carrier-only despite cnt=1, ch7 summed despite cnt=0, both doubled
    cnt = '0;
    cnt[0][6] = 1'b1;
    ryt = 1'b1;
    op(0, 6, 0, 50);
    op(0, 6, 1, 10);
    frame("ryt_ch6", 20, 20);
    op(0, 7, 0, 5);
    op(0, 7, 1, 5);
    frame("ryt_ch7", 20, 20);
    ryt = 1'b0;

    // Modulator cleared at frame end, and overwrite within a frame
    cnt = '0;
    cnt[0][0] = 1'b1;
    op(0, 0, 0, 300);
    frame("nomod_a", 0, 0);
    op(0, 0, 1, 123);
    frame("nomod_b", 123, 123);
    op(0, 0, 0, 100);
    op(0, 0, 0, 7);
    op(0, 0, 1, 1);
    frame("mod_ovr", 8, 8);

    // Out-of-range channel ignored, bank 1 ch 8 counted
    cnt = '0;
    op(0, 12, 1, 555);
    op(0, 9, 1, 321);
    op(1, 8, 1, 77);
    frame("range", 77, 77);

    // Carrier in the strobe cycle lands in the next frame
    sample_clk_en = 1'b1;
    op(0, 0, 1, 1000);
    sample_clk_en = 1'b0;
    check("bnd_valid", int'(sample_valid), 1);
    check("bnd_cur_l", int'(sample_l), 0);
    check("bnd_cur_r", int'(sample_r), 0);
    cycle();
    frame("bnd_next", 1000, 1000);

    // Reset mid-frame discards the partial frame
    op(0, 0, 1, 500);
    reset = 1'b1;
    #1;
    check("midrst_l", int'(sample_l), 0);
    check("midrst_r", int'(sample_r), 0);
    check("midrst_valid", int'(sample_valid), 0);
`ifdef CHANNEL_MIXER_CLIP_CNT_EN
    check("midrst_clip", int'(clip_count), 0);
`endif
    cycle();
    reset = 1'b0;
    cycle();
    frame("rst_next", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
